// File: rtl/machine_control_unit_if.sv
// Bundle of decode status, CSR interrupt state and trap-control outputs
// exchanged between the core pipeline/CSR file and machine_control_unit.
// Handshake rule: this is a level-based control bus; every signal is
// sampled on the rising clock edge, there is no valid/ready pairing.
// The "master" side is the core environment, which drives the status and
// receives the controls. The "slave" side is the control unit itself.
// state_out exposes the FSM state for observation only.
interface machine_control_unit_if;
    logic       stall_in;
    logic       illegal_instr_in;
    logic       misaligned_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs2_addr_in;
    logic       mie_in;
    logic       meie_in;
    logic       mtie_in;
    logic       msie_in;
    logic       meip_in;
    logic       mtip_in;
    logic       msip_in;

    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_cause_out;
    logic       set_epc_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic       instret_inc_out;
    logic [1:0] pc_src_out;
    logic       flush_out;
    logic       wfi_stall_out;
    logic [2:0] state_out;

    modport master (
        output stall_in, illegal_instr_in, misaligned_instr_in,
               misaligned_load_in, misaligned_store_in, opcode_6_to_2_in,
               funct3_in, funct7_in, rs2_addr_in, mie_in, meie_in, mtie_in,
               msie_in, meip_in, mtip_in, msip_in,
        input  i_or_e_out, cause_out, set_cause_out, set_epc_out,
               mie_clear_out, mie_set_out, instret_inc_out, pc_src_out,
               flush_out, wfi_stall_out, state_out
    );

    modport slave (
        input  stall_in, illegal_instr_in, misaligned_instr_in,
               misaligned_load_in, misaligned_store_in, opcode_6_to_2_in,
               funct3_in, funct7_in, rs2_addr_in, mie_in, meie_in, mtie_in,
               msie_in, meip_in, mtip_in, msip_in,
        output i_or_e_out, cause_out, set_cause_out, set_epc_out,
               mie_clear_out, mie_set_out, instret_inc_out, pc_src_out,
               flush_out, wfi_stall_out, state_out
    );
endinterface

// File: rtl/machine_control_unit.sv
// Machine-mode trap/return sequencer for the RV32 core.
// Prioritises synchronous exceptions over interrupts, sequences MRET,
// selects the next-PC source and flushes the pipeline on redirects.
// Optional feature macro: WFI_EN -- adds the WAIT state so WFI halts the
// core until an enabled interrupt is pending. Without it WFI is a NOP.
module machine_control_unit #(
    parameter int RESET_CYCLES = 1   // cycles spent in RESET, 1..15
) (
    input logic               clk_in,
    input logic               rst_in,
    machine_control_unit_if.slave bus
);

`ifdef WFI_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_RESET       = STATE_W'(0),
        S_OPERATING   = STATE_W'(1),
        S_TRAP_TAKEN  = STATE_W'(2),
`ifdef WFI_EN
        S_TRAP_RETURN = STATE_W'(3),
        S_WAIT        = STATE_W'(4)
`else
        S_TRAP_RETURN = STATE_W'(3)
`endif
    } state_t;

    localparam logic [3:0] RESET_LAST = 4'(RESET_CYCLES - 1);

    state_t     state;
    logic [3:0] counter;
    logic [3:0] cause_q;
    logic       i_or_e_q;

    logic       is_system;
    logic       is_ecall;
    logic       is_ebreak;
    logic       is_mret;
    logic       irq_ext;
    logic       irq_tmr;
    logic       irq_sw;
    logic       trap;
    logic [3:0] trap_cause;
    logic       trap_is_irq;

    logic [1:0] pc_src;
    logic       flush;
    logic       instret_inc;
    logic       set_cause;
    logic       set_epc;
    logic       mie_clear;
    logic       mie_set;
    logic       wfi_stall;

    // SYSTEM-opcode decode and per-source pending-and-enabled interrupts.
    always_comb begin
        is_system = (bus.opcode_6_to_2_in == 5'b11100) && (bus.funct3_in == 3'b000);
        is_ecall  = is_system && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'b00000);
        is_ebreak = is_system && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'b00001);
        is_mret   = is_system && (bus.funct7_in == 7'b0011000) && (bus.rs2_addr_in == 5'b00010);
        irq_ext   = bus.meip_in & bus.meie_in;
        irq_tmr   = bus.mtip_in & bus.mtie_in;
        irq_sw    = bus.msip_in & bus.msie_in;
    end

    // First-match trap priority: exceptions first, then mie-gated interrupts.
    always_comb begin
        trap        = 1'b1;
        trap_cause  = 4'd0;
        trap_is_irq = 1'b0;
        if (bus.illegal_instr_in)         trap_cause = 4'd2;
        else if (bus.misaligned_instr_in) trap_cause = 4'd0;
        else if (is_ecall)                trap_cause = 4'd11;
        else if (is_ebreak)               trap_cause = 4'd3;
        else if (bus.misaligned_load_in)  trap_cause = 4'd4;
        else if (bus.misaligned_store_in) trap_cause = 4'd6;
        else if (bus.mie_in && irq_ext) begin
            trap_cause  = 4'd11;
            trap_is_irq = 1'b1;
        end else if (bus.mie_in && irq_sw) begin
            trap_cause  = 4'd3;
            trap_is_irq = 1'b1;
        end else if (bus.mie_in && irq_tmr) begin
            trap_cause  = 4'd7;
            trap_is_irq = 1'b1;
        end else begin
            trap = 1'b0;
        end
    end

    // Sequencer state, reset counter and captured trap cause; frozen by stall.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= S_RESET;
            counter  <= 4'd0;
            cause_q  <= 4'd0;
            i_or_e_q <= 1'b0;
        end else if (!bus.stall_in) begin
            case (state)
                S_RESET: begin
                    if (counter == RESET_LAST) state <= S_OPERATING;
                    else                       counter <= counter + 4'd1;
                end
                S_OPERATING: begin
                    if (trap) begin
                        cause_q  <= trap_cause;
                        i_or_e_q <= trap_is_irq;
                        state    <= S_TRAP_TAKEN;
                    end else if (is_mret) begin
                        state <= S_TRAP_RETURN;
`ifdef WFI_EN
                    end else if (is_system && (bus.funct7_in == 7'b0001000) &&
                                 (bus.rs2_addr_in == 5'b00101)) begin
                        state <= S_WAIT;
`endif
                    end
                end
                S_TRAP_TAKEN:  state <= S_OPERATING;
                S_TRAP_RETURN: state <= S_OPERATING;
`ifdef WFI_EN
                S_WAIT: begin
                    if (irq_ext || irq_tmr || irq_sw) state <= S_OPERATING;
                end
`endif
                default: state <= S_RESET;
            endcase
        end
    end

    // Control outputs decoded from the held state plus the current decode.
    always_comb begin
        pc_src      = 2'b11;
        flush       = 1'b0;
        instret_inc = 1'b0;
        set_cause   = 1'b0;
        set_epc     = 1'b0;
        mie_clear   = 1'b0;
        mie_set     = 1'b0;
        wfi_stall   = 1'b0;
        case (state)
            S_RESET: begin
                pc_src = 2'b00;
                flush  = 1'b1;
            end
            S_OPERATING: begin
                if (!bus.stall_in) begin
                    if (trap) begin
                        flush = 1'b1;
                    end else if (is_mret) begin
                        flush       = 1'b1;
                        instret_inc = 1'b1;
                    end else begin
                        instret_inc = 1'b1;
                    end
                end
            end
            S_TRAP_TAKEN: begin
                set_cause = 1'b1;
                set_epc   = 1'b1;
                mie_clear = 1'b1;
                pc_src    = 2'b10;
                flush     = 1'b1;
            end
            S_TRAP_RETURN: begin
                mie_set = 1'b1;
                pc_src  = 2'b01;
                flush   = 1'b1;
            end
`ifdef WFI_EN
            S_WAIT: wfi_stall = 1'b1;
`endif
            default: begin
                pc_src = 2'b00;
                flush  = 1'b1;
            end
        endcase
    end

    assign bus.pc_src_out      = pc_src;
    assign bus.flush_out       = flush;
    assign bus.instret_inc_out = instret_inc;
    assign bus.set_cause_out   = set_cause;
    assign bus.set_epc_out     = set_epc;
    assign bus.mie_clear_out   = mie_clear;
    assign bus.mie_set_out     = mie_set;
    assign bus.wfi_stall_out   = wfi_stall;
    assign bus.cause_out       = cause_q;
    assign bus.i_or_e_out      = i_or_e_q;
    assign bus.state_out       = 3'(state);

endmodule

// File: tb/tb_machine_control_unit.sv
// Self-checking bench for machine_control_unit (RESET_CYCLES=3).
module tb_machine_control_unit;

  localparam int RC = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  machine_control_unit_if bus();

  machine_control_unit #(.RESET_CYCLES(RC)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  // Model view: a countdown of boot cycles, a queue of forced one-cycle
  // redirects (1 = trap entry, 2 = return), a waiting flag, and the last
  // captured cause. Everything else follows from the trap rules.
  int         reset_left;
  logic [1:0] exp_q[$];
  bit         waiting;
  int         m_cause;
  int         m_ioe;

  always @(negedge clk) begin : compare
    int  e_pc, e_fl, e_ir, e_sc, e_se, e_mc, e_ms, e_ws, e_cause, e_ioe;
    bit  cond[9];
    int  cs[9];
    bit  sys, ecall, ebreak, mret, wfi, hit;
    int  hit_idx;
    e_pc = 3; e_fl = 0; e_ir = 0; e_sc = 0; e_se = 0; e_mc = 0; e_ms = 0; e_ws = 0;
    sys    = (bus.opcode_6_to_2_in == 5'b11100) && (bus.funct3_in == 3'd0);
    ecall  = sys && bus.funct7_in == 7'd0  && bus.rs2_addr_in == 5'd0;
    ebreak = sys && bus.funct7_in == 7'd0  && bus.rs2_addr_in == 5'd1;
    mret   = sys && bus.funct7_in == 7'd24 && bus.rs2_addr_in == 5'd2;
    wfi    = sys && bus.funct7_in == 7'd8  && bus.rs2_addr_in == 5'd5;
    if (!rst_n) begin
      reset_left = RC; exp_q.delete(); waiting = 0; m_cause = 0; m_ioe = 0;
      e_pc = 0; e_fl = 1;
    end
    e_cause = m_cause;
    e_ioe   = m_ioe;
    if (!rst_n) begin
      // outputs already set above
    end else if (reset_left > 0) begin
      e_pc = 0; e_fl = 1;
      if (!bus.stall_in) reset_left--;
    end else if (exp_q.size() > 0) begin
      e_fl = 1;
      if (exp_q[0] == 2'd1) begin
        e_sc = 1; e_se = 1; e_mc = 1; e_pc = 2;
      end else begin
        e_ms = 1; e_pc = 1;
      end
      if (!bus.stall_in) void'(exp_q.pop_front());
    end else if (waiting) begin
      e_ws = 1;
      if (!bus.stall_in && ((bus.meip_in && bus.meie_in) || (bus.mtip_in && bus.mtie_in) ||
                            (bus.msip_in && bus.msie_in)))
        waiting = 0;
    end else if (!bus.stall_in) begin
      cond = '{bus.illegal_instr_in, bus.misaligned_instr_in, ecall, ebreak,
               bus.misaligned_load_in, bus.misaligned_store_in,
               bus.mie_in && bus.meip_in && bus.meie_in,
               bus.mie_in && bus.msip_in && bus.msie_in,
               bus.mie_in && bus.mtip_in && bus.mtie_in};
      cs = '{2, 0, 11, 3, 4, 6, 11, 3, 7};
      hit = 0; hit_idx = 0;
      for (int i = 0; i < 9; i++)
        if (!hit && cond[i]) begin hit = 1; hit_idx = i; end
      if (hit) begin
        e_fl = 1;
        m_cause = cs[hit_idx];
        m_ioe = (hit_idx >= 6) ? 1 : 0;
        exp_q.push_back(2'd1);
      end else if (mret) begin
        e_fl = 1; e_ir = 1;
        exp_q.push_back(2'd2);
      end else begin
        e_ir = 1;
`ifdef WFI_EN
        if (wfi) waiting = 1;
`else
        if (wfi) e_ir = 1;  // WFI retires like any other instruction
`endif
      end
    end
    chk("pc_src", int'(bus.pc_src_out), e_pc);
    chk("flush", int'(bus.flush_out), e_fl);
    chk("instret_inc", int'(bus.instret_inc_out), e_ir);
    chk("set_cause", int'(bus.set_cause_out), e_sc);
    chk("set_epc", int'(bus.set_epc_out), e_se);
    chk("mie_clear", int'(bus.mie_clear_out), e_mc);
    chk("mie_set", int'(bus.mie_set_out), e_ms);
    chk("wfi_stall", int'(bus.wfi_stall_out), e_ws);
    chk("cause", int'(bus.cause_out), e_cause);
    chk("i_or_e", int'(bus.i_or_e_out), e_ioe);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    bus.stall_in = 0; bus.illegal_instr_in = 0; bus.misaligned_instr_in = 0;
    bus.misaligned_load_in = 0; bus.misaligned_store_in = 0;
    bus.opcode_6_to_2_in = 5'b01100; bus.funct3_in = 0; bus.funct7_in = 0;
    bus.rs2_addr_in = 0; bus.mie_in = 0; bus.meie_in = 0; bus.mtie_in = 0;
    bus.msie_in = 0; bus.meip_in = 0; bus.mtip_in = 0; bus.msip_in = 0;
  endtask

  task automatic set_system(input logic [6:0] f7, input logic [4:0] rs2);
    bus.opcode_6_to_2_in = 5'b11100; bus.funct3_in = 3'd0;
    bus.funct7_in = f7; bus.rs2_addr_in = rs2;
  endtask

  task automatic rand_inputs();
    int r;
    bus.stall_in            = ($urandom_range(0, 9) == 0);
    bus.illegal_instr_in    = ($urandom_range(0, 19) == 0);
    bus.misaligned_instr_in = ($urandom_range(0, 24) == 0);
    bus.misaligned_load_in  = ($urandom_range(0, 24) == 0);
    bus.misaligned_store_in = ($urandom_range(0, 24) == 0);
    r = $urandom_range(0, 9);
    case (r)
      0: set_system(7'd0, 5'd0);
      1: set_system(7'd0, 5'd1);
      2, 3: set_system(7'd24, 5'd2);
      4: set_system(7'd8, 5'd5);
      5: set_system(7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)));
      default: begin
        bus.opcode_6_to_2_in = 5'($urandom_range(0, 31));
        bus.funct3_in = 3'($urandom_range(0, 7));
        bus.funct7_in = 7'($urandom_range(0, 127));
        bus.rs2_addr_in = 5'($urandom_range(0, 31));
      end
    endcase
    bus.mie_in  = $urandom_range(0, 1) == 1;
    bus.meie_in = $urandom_range(0, 1) == 1;
    bus.mtie_in = $urandom_range(0, 1) == 1;
    bus.msie_in = $urandom_range(0, 1) == 1;
    bus.meip_in = $urandom_range(0, 7) == 0;
    bus.mtip_in = $urandom_range(0, 7) == 0;
    bus.msip_in = $urandom_range(0, 7) == 0;
  endtask

  // ---------------- directed pins + random run ----------------
  initial begin
    checks = 0; errors = 0;
    reset_left = RC; waiting = 0; m_cause = 0; m_ioe = 0;
    rst_n = 1'b0;
    idle();
    tick(); tick();
    at_neg();
    chk("rst_pc_src", int'(bus.pc_src_out), 0);
    chk("rst_flush", int'(bus.flush_out), 1);
    chk("rst_cause", int'(bus.cause_out), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < RC; k++) begin
      at_neg();
      chk("boot_pc_src", int'(bus.pc_src_out), 0);
      chk("boot_flush", int'(bus.flush_out), 1);
      tick();
    end
    at_neg();
    chk("run_pc_src", int'(bus.pc_src_out), 3);
    chk("run_flush", int'(bus.flush_out), 0);

    // illegal + ECALL + enabled external interrupt: illegal wins
    tick();
    bus.illegal_instr_in = 1; set_system(7'd0, 5'd0);
    bus.meip_in = 1; bus.meie_in = 1; bus.mie_in = 1;
    at_neg();
    chk("det_flush", int'(bus.flush_out), 1);
    chk("det_instret", int'(bus.instret_inc_out), 0);
    tick(); idle();
    at_neg();
    chk("ill_cause", int'(bus.cause_out), 2);
    chk("ill_i_or_e", int'(bus.i_or_e_out), 0);
    chk("ill_set_cause", int'(bus.set_cause_out), 1);
    chk("ill_set_epc", int'(bus.set_epc_out), 1);
    chk("ill_mie_clear", int'(bus.mie_clear_out), 1);
    chk("ill_pc_src", int'(bus.pc_src_out), 2);
    tick();
    at_neg();
    chk("post_trap_pc_src", int'(bus.pc_src_out), 3);

    // timer interrupt, enabled then globally masked
    tick();
    bus.mie_in = 1; bus.mtie_in = 1; bus.mtip_in = 1;
    at_neg();
    tick(); idle();
    at_neg();
    chk("tmr_cause", int'(bus.cause_out), 7);
    chk("tmr_i_or_e", int'(bus.i_or_e_out), 1);
    tick();
    bus.mie_in = 0; bus.mtie_in = 1; bus.mtip_in = 1;
    at_neg();
    chk("masked_flush", int'(bus.flush_out), 0);
    chk("masked_instret", int'(bus.instret_inc_out), 1);
    tick();
    at_neg();
    chk("masked_set_cause", int'(bus.set_cause_out), 0);
    chk("masked_pc_src", int'(bus.pc_src_out), 3);
    idle();

    // MRET sequence
    tick();
    set_system(7'd24, 5'd2);
    at_neg();
    chk("mret_instret", int'(bus.instret_inc_out), 1);
    chk("mret_flush", int'(bus.flush_out), 1);
    tick(); idle();
    at_neg();
    chk("mret_mie_set", int'(bus.mie_set_out), 1);
    chk("mret_pc_src", int'(bus.pc_src_out), 1);
    tick();
    at_neg();
    chk("mret_after_pc_src", int'(bus.pc_src_out), 3);

    // stall held in TRAP_TAKEN
    tick();
    bus.misaligned_load_in = 1;
    at_neg();
    tick(); idle(); bus.stall_in = 1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("stall_set_cause", int'(bus.set_cause_out), 1);
      chk("stall_pc_src", int'(bus.pc_src_out), 2);
      tick();
    end
    bus.stall_in = 0;
    at_neg();
    chk("release_set_cause", int'(bus.set_cause_out), 1);
    chk("release_cause", int'(bus.cause_out), 4);
    tick();
    at_neg();
    chk("release_pc_src", int'(bus.pc_src_out), 3);

    // randomized run with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        rand_inputs();
        repeat ($urandom_range(1, 3)) tick();
        rst_n = 1'b1;
      end
      rand_inputs();
    end
    tick(); idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
